// File: rtl/fact_dp_arbiter.sv
// fact_dp_arbiter: round-robin front end sharing one factorial datapath
// between N_REQ requesters. Latches the winner's operand, pulses dp_start,
// waits for dp_done under a RUN watchdog and returns the result on a
// valid/ready response channel tagged with the requester id.
module fact_dp_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*DATA_W-1:0]  req_data,
  output logic [N_REQ-1:0]         gnt,
  output logic                     busy,
  output logic                     dp_start,
  output logic [DATA_W-1:0]        dp_data_in,
  input  logic                     dp_done,
  input  logic [DATA_W-1:0]        dp_data_out,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_W-1:0]        rsp_data,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic                     rsp_err
);

  localparam int ID_W = $clog2(N_REQ);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [ID_W-1:0] ID_LAST = ID_W'(N_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_START,
    S_RUN,
    S_RESP
  } state_t;

  state_t               state_q, state_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic [N_REQ-1:0]     gnt_q, gnt_d;
  logic                 busy_q, busy_d;
  logic                 dp_start_q, dp_start_d;
  logic [DATA_W-1:0]    dp_data_in_q, dp_data_in_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]    rsp_data_q, rsp_data_d;
  logic                 rsp_err_q, rsp_err_d;

  logic                 win_found;
  logic [ID_W-1:0]      win_id;
  logic [ID_W-1:0]      scan_idx;
  logic [DATA_W-1:0]    req_slice [N_REQ];

  // Unpack the flat operand bus into one slice per requester.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign req_slice[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Round-robin search: first asserted req starting at rr_ptr, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    scan_idx  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = ID_W'((int'(rr_ptr_q) + k) % N_REQ);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_id    = scan_idx;
      end
    end
  end

  // Next-state and next-output decode; every output is registered.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    id_d         = id_q;
    wd_d         = wd_q;
    gnt_d        = '0;
    busy_d       = busy_q;
    dp_start_d   = 1'b0;
    dp_data_in_d = dp_data_in_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d      = S_GRANT;
          id_d         = win_id;
          dp_data_in_d = req_slice[win_id];
          gnt_d        = N_REQ'(1) << win_id;
          busy_d       = 1'b1;
        end
      end
      S_GRANT: begin
        state_d    = S_START;
        dp_start_d = 1'b1;
      end
      S_START: begin
        state_d = S_RUN;
        wd_d    = '0;
      end
      S_RUN: begin
        // A completion in the last watchdog cycle still wins.
        if (dp_done) begin
          state_d     = S_RESP;
          rsp_data_d  = dp_data_out;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
        end else if (wd_q == WD_LAST) begin
          state_d     = S_RESP;
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          busy_d      = 1'b0;
          rr_ptr_d    = (id_q == ID_LAST) ? '0 : id_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      id_q         <= '0;
      wd_q         <= '0;
      gnt_q        <= '0;
      busy_q       <= 1'b0;
      dp_start_q   <= 1'b0;
      dp_data_in_q <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      id_q         <= id_d;
      wd_q         <= wd_d;
      gnt_q        <= gnt_d;
      busy_q       <= busy_d;
      dp_start_q   <= dp_start_d;
      dp_data_in_q <= dp_data_in_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign gnt        = gnt_q;
  assign busy       = busy_q;
  assign dp_start   = dp_start_q;
  assign dp_data_in = dp_data_in_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_id     = id_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_fact_dp_arbiter.sv
// Testbench for fact_dp_arbiter: randomized requests, operands, datapath
// latency and response backpressure, checked against a spec-level model
// (round-robin pick by modular scan, factorial result, watchdog limit).
module tb_fact_dp_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     gnt;
  logic             busy;
  logic             dp_start;
  logic [W-1:0]     dp_data_in;
  logic             dp_done;
  logic [W-1:0]     dp_data_out;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [W-1:0]     rsp_data;
  logic [1:0]       rsp_id;
  logic             rsp_err;

  logic [W-1:0]     op [N];
  int               n_vec = 0;
  int               n_err = 0;
  int               exp_ptr = 0;

  fact_dp_arbiter #(.N_REQ(N), .DATA_W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt),
    .busy(busy), .dp_start(dp_start), .dp_data_in(dp_data_in),
    .dp_done(dp_done), .dp_data_out(dp_data_out), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id),
    .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  assign req_data = {op[3], op[2], op[1], op[0]};

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  // Reference factorial, truncated to the datapath width.
  function automatic logic [W-1:0] fact_ref(input logic [W-1:0] n);
    int unsigned r;
    r = 1;
    for (int unsigned k = 2; k <= n; k++) r = (r * k) % 256;
    return W'(r);
  endfunction

  // Reference arbitration: first requester at ptr, ptr+1, ... modulo N.
  function automatic int pick(input logic [N-1:0] pat, input int ptr);
    for (int k = 0; k < N; k++) if (pat[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction starting from IDLE; done_at = RUN cycle with dp_done
  // (out of 1..TO means never seen), ready_wait = cycles of rsp_ready=0.
  task automatic run_txn(input logic [N-1:0] pat, input int done_at,
                         input int ready_wait, input logic [N-1:0] pend,
                         output int got_id);
    int           wid;
    int           exp_cyc;
    int           cyc;
    bit           got;
    bit           exp_err;
    logic [W-1:0] operand;
    logic [W-1:0] exp_res;
    logic [N-1:0] exp_gnt;
    got_id = -1;
    wid = pick(pat, exp_ptr);
    if (wid < 0) return;
    operand = op[wid];
    exp_err = !(done_at >= 1 && done_at <= TO);
    exp_cyc = exp_err ? TO : done_at;
    exp_res = exp_err ? '0 : fact_ref(operand);
    exp_gnt = '0;
    exp_gnt[wid] = 1'b1;

    req = pat;
    step();
    n_vec++;
    if (gnt !== exp_gnt || busy !== 1'b1 || dp_start !== 1'b0 || dp_data_in !== operand) begin
      n_err++;
      $display("FAIL grant: gnt=%b busy=%b start=%b din=%0d, required gnt=%b busy=1 start=0 din=%0d",
               gnt, busy, dp_start, dp_data_in, exp_gnt, operand);
    end
    req[wid] = 1'b0;
    for (int i = 0; i < N; i++) op[i] = W'($urandom_range(0, 10));
    dp_done = 1'b1;
    dp_data_out = W'($urandom);
    step();
    n_vec++;
    if (dp_start !== 1'b1 || gnt !== '0 || busy !== 1'b1 || dp_data_in !== operand) begin
      n_err++;
      $display("FAIL start: start=%b gnt=%b busy=%b din=%0d, required start=1 gnt=0 busy=1 din=%0d",
               dp_start, gnt, busy, dp_data_in, operand);
    end
    step();
    n_vec++;
    if (dp_start !== 1'b0 || busy !== 1'b1 || rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL run_entry: start=%b busy=%b valid=%b, required start=0 busy=1 valid=0",
               dp_start, busy, rsp_valid);
    end

    got = 1'b0;
    cyc = 0;
    for (int c = 1; c <= TO + 8 && !got; c++) begin
      dp_done = (c == done_at);
      dp_data_out = (c == done_at) ? fact_ref(operand) : W'($urandom);
      step();
      if (rsp_valid === 1'b1) begin
        got = 1'b1;
        cyc = c;
      end
    end
    dp_done = 1'b0;
    n_vec++;
    if (!got || cyc != exp_cyc) begin
      n_err++;
      $display("FAIL latency: rsp_valid after %0d RUN cycles (seen=%0d), required %0d",
               cyc, got, exp_cyc);
    end
    if (!got) return;
    n_vec++;
    if (rsp_data !== exp_res || rsp_id !== 2'(wid) || rsp_err !== exp_err ||
        busy !== 1'b1 || dp_data_in !== operand) begin
      n_err++;
      $display("FAIL response: data=%0d id=%0d err=%b busy=%b din=%0d, required data=%0d id=%0d err=%b busy=1 din=%0d",
               rsp_data, rsp_id, rsp_err, busy, dp_data_in, exp_res, wid, exp_err, operand);
    end
    got_id = int'(rsp_id);

    req = req | pend;
    for (int w = 0; w < ready_wait; w++) begin
      rsp_ready = 1'b0;
      dp_done = 1'($urandom_range(0, 1));
      dp_data_out = W'($urandom);
      step();
      n_vec++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp_res || rsp_id !== 2'(wid) ||
          rsp_err !== exp_err || gnt !== '0 || dp_data_in !== operand) begin
        n_err++;
        $display("FAIL hold: cycle %0d valid=%b data=%0d id=%0d err=%b gnt=%b din=%0d, required valid=1 data=%0d id=%0d err=%b gnt=0 din=%0d",
                 w, rsp_valid, rsp_data, rsp_id, rsp_err, gnt, dp_data_in, exp_res, wid, exp_err, operand);
      end
    end
    dp_done = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    n_vec++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || gnt !== '0) begin
      n_err++;
      $display("FAIL handshake: valid=%b busy=%b gnt=%b, required valid=0 busy=0 gnt=0",
               rsp_valid, busy, gnt);
    end
    exp_ptr = (wid + 1) % N;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = '0;
    rsp_ready = 1'b0;
    dp_done = 1'b0;
    dp_data_out = '0;
    for (int i = 0; i < N; i++) op[i] = '0;
    #1;
    n_vec++;
    if ({gnt, busy, dp_start, dp_data_in, rsp_valid, rsp_data, rsp_id, rsp_err} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: gnt=%b busy=%b start=%b din=%0d valid=%b data=%0d id=%0d err=%b, required all 0",
               gnt, busy, dp_start, dp_data_in, rsp_valid, rsp_data, rsp_id, rsp_err);
    end
    req = 4'b1111;
    step();
    step();
    n_vec++;
    if (gnt !== '0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hold: gnt=%b busy=%b, required gnt=0 busy=0", gnt, busy);
    end
    req = '0;
    rst_n = 1'b1;
    exp_ptr = 0;
    step();
    n_vec++;
    if (gnt !== '0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_no_req: gnt=%b busy=%b, required gnt=0 busy=0", gnt, busy);
    end
  endtask

  task automatic test_round_robin();
    int           order [5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] seen;
    int           id;
    seen = '0;
    for (int k = 0; k < 5; k++) begin
      run_txn(4'b1111, $urandom_range(1, 12), 0, 4'b0000, id);
      n_vec++;
      if (id != order[k]) begin
        n_err++;
        $display("FAIL rr_order: step %0d granted id %0d, required %0d", k, id, order[k]);
      end
      if (k < 4 && id >= 0 && id < N) begin
        n_vec++;
        if (seen[id]) begin
          n_err++;
          $display("FAIL rr_fair: id %0d granted twice in first round, required once", id);
        end
        seen[id] = 1'b1;
      end
    end
  endtask

  task automatic test_single();
    int id;
    op[2] = 8'd5;
    run_txn(4'b0100, 8, 0, 4'b0000, id);
    n_vec++;
    if (id != 2) begin
      n_err++;
      $display("FAIL single_id: got %0d, required 2", id);
    end
  endtask

  task automatic test_pointer_wrap();
    int id;
    run_txn(4'b1001, 5, 0, 4'b0000, id);
    n_vec++;
    if (id != 3) begin
      n_err++;
      $display("FAIL wrap_first: got %0d, required 3", id);
    end
    run_txn(4'b0001, 5, 0, 4'b0000, id);
    n_vec++;
    if (id != 0) begin
      n_err++;
      $display("FAIL wrap_second: got %0d, required 0", id);
    end
  endtask

  task automatic test_backpressure();
    int id;
    run_txn(4'b0100, 4, 6, 4'b0001, id);
    run_txn(4'b0001, 3, 0, 4'b0000, id);
    n_vec++;
    if (id != 0) begin
      n_err++;
      $display("FAIL bp_pending: got %0d, required 0", id);
    end
  endtask

  task automatic test_watchdog();
    int id;
    run_txn(4'(1 << $urandom_range(0, 3)), -1, 1, 4'b0000, id);
    run_txn(4'(1 << $urandom_range(0, 3)), TO, 0, 4'b0000, id);
    run_txn(4'(1 << $urandom_range(0, 3)), TO + 1, 2, 4'b0000, id);
  endtask

  task automatic test_reset_mid_run();
    int id;
    op[2] = 8'd7;
    req = 4'b0100;
    step();
    req[2] = 1'b0;
    dp_done = 1'b0;
    step();
    step();
    step();
    step();
    n_vec++;
    if (busy !== 1'b1 || dp_data_in !== 8'd7) begin
      n_err++;
      $display("FAIL mid_run_busy: busy=%b din=%0d, required busy=1 din=7", busy, dp_data_in);
    end
    #3;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({gnt, busy, dp_start, dp_data_in, rsp_valid, rsp_data, rsp_id, rsp_err} !== '0) begin
      n_err++;
      $display("FAIL async_reset: gnt=%b busy=%b start=%b din=%0d valid=%b data=%0d id=%0d err=%b, required all 0",
               gnt, busy, dp_start, dp_data_in, rsp_valid, rsp_data, rsp_id, rsp_err);
    end
    req = 4'b0010;
    step();
    rst_n = 1'b1;
    exp_ptr = 0;
    run_txn(4'b0010, 6, 0, 4'b0000, id);
    n_vec++;
    if (id != 1) begin
      n_err++;
      $display("FAIL after_reset_id: got %0d, required 1", id);
    end
    run_txn(4'b1011, 9, 1, 4'b0000, id);
  endtask

  task automatic test_random();
    int id;
    for (int t = 0; t < 24; t++) begin
      run_txn(4'($urandom_range(1, 15)), $urandom_range(1, TO + 3),
              $urandom_range(0, 3), 4'($urandom_range(0, 15)), id);
      req = '0;
      repeat ($urandom_range(0, 2)) begin
        step();
        n_vec++;
        if (busy !== 1'b0 || gnt !== '0) begin
          n_err++;
          $display("FAIL idle_gap: busy=%b gnt=%b, required busy=0 gnt=0", busy, gnt);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_pointer_wrap();
    test_backpressure();
    test_watchdog();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
